// File: rtl/cnn_issuer_pkg.sv
// Shared constants and state encoding for the CNN instruction issuer.
package cnn_issuer_pkg;

  localparam int INST_W_DEF = 128;

  localparam logic [7:0] CMD_RESET = 8'd1;
  localparam logic [7:0] CMD_START = 8'd2;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SEND_RST,
    ST_FETCH,
    ST_ISSUE,
    ST_GAP,
    ST_SEND_START,
    ST_WAIT_BUSY,
    ST_WAIT_IDLE,
    ST_DONE
  } issuer_state_e;

endpackage

// File: rtl/cnn_inst_issuer_if.sv
// Instruction port between the issuer (master) and the CNN executor (slave).
interface cnn_inst_issuer_if
  import cnn_issuer_pkg::*;
#(
  parameter int INST_W = INST_W_DEF
) ();

  logic [INST_W-1:0] cnn_inst;
  logic              cnn_inst_en;
  logic              cnn_inst_ready;

  modport master (
    output cnn_inst,
    output cnn_inst_en,
    input  cnn_inst_ready
  );

  modport slave (
    input  cnn_inst,
    input  cnn_inst_en,
    output cnn_inst_ready
  );

endinterface

// File: rtl/cnn_inst_ram.sv
// Simple dual-port instruction RAM: one write port, one read port, 1-cycle read latency.
module cnn_inst_ram
  import cnn_issuer_pkg::*;
#(
  parameter int DATA_W = INST_W_DEF,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // Contents survive reset; the program is reloaded only by the host.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/cnn_inst_issuer.sv
// Sequencer feeding the CNN executor: RESET command, N program words from RAM,
// START command, then waits for the executor to go busy and return to idle.
module cnn_inst_issuer
  import cnn_issuer_pkg::*;
#(
  parameter int INST_W   = INST_W_DEF,
  parameter int ADDR_W   = 10,
  parameter int GAP_CYC  = 3,
  parameter int BUSY_TMO = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en_i,
  input  logic [ADDR_W-1:0]   wr_addr_i,
  input  logic [INST_W-1:0]   wr_data_i,
  input  logic                run_i,
  input  logic [ADDR_W:0]     inst_count_i,
  cnn_inst_issuer_if.master   exec_if,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_tmo_o
);

  localparam int GAP_W = $clog2(GAP_CYC + 1);
  localparam int TMO_W = $clog2(BUSY_TMO + 1);
  localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(2**ADDR_W);

  issuer_state_e     state_q;
  logic [INST_W-1:0] inst_q;
  logic              en_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic              start_sent_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   rem_q;
  logic [GAP_W-1:0]  gap_q;
  logic [TMO_W-1:0]  tmo_q;

  logic [ADDR_W:0]   count_sat;
  logic              gap_done;
  logic              ram_re;
  logic              ram_we;
  logic [INST_W-1:0] ram_rdata;

  assign count_sat = (inst_count_i > MAX_CNT) ? MAX_CNT : inst_count_i;
  assign gap_done  = (state_q == ST_GAP) && (gap_q == '0);
  // The read is launched on the edge leaving GAP so the word is ready by the end of FETCH.
  assign ram_re    = gap_done && !start_sent_q && (rem_q != '0);
  assign ram_we    = wr_en_i && !busy_q;

  cnn_inst_ram #(
    .DATA_W (INST_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (wr_addr_i),
    .wdata_i (wr_data_i),
    .re_i    (ram_re),
    .raddr_i (addr_q),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      inst_q       <= '0;
      en_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      start_sent_q <= 1'b0;
      addr_q       <= '0;
      rem_q        <= '0;
      gap_q        <= '0;
      tmo_q        <= '0;
    end else begin
      en_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (run_i) begin
            rem_q        <= count_sat;
            addr_q       <= '0;
            err_q        <= 1'b0;
            busy_q       <= 1'b1;
            start_sent_q <= 1'b0;
            inst_q       <= INST_W'(CMD_RESET);
            en_q         <= 1'b1;
            state_q      <= ST_SEND_RST;
          end
        end
        ST_SEND_RST, ST_ISSUE, ST_SEND_START: begin
          gap_q   <= GAP_W'(GAP_CYC - 1);
          state_q <= ST_GAP;
        end
        ST_GAP: begin
          if (gap_q != '0) begin
            gap_q <= gap_q - 1'b1;
          end else if (start_sent_q) begin
            tmo_q   <= '0;
            state_q <= ST_WAIT_BUSY;
          end else if (rem_q != '0) begin
            rem_q   <= rem_q - 1'b1;
            addr_q  <= addr_q + 1'b1;
            state_q <= ST_FETCH;
          end else begin
            inst_q       <= INST_W'(CMD_START);
            en_q         <= 1'b1;
            start_sent_q <= 1'b1;
            state_q      <= ST_SEND_START;
          end
        end
        ST_FETCH: begin
          inst_q  <= ram_rdata;
          en_q    <= 1'b1;
          state_q <= ST_ISSUE;
        end
        ST_WAIT_BUSY: begin
          if (!exec_if.cnn_inst_ready) begin
            state_q <= ST_WAIT_IDLE;
          end else if (tmo_q == TMO_W'(BUSY_TMO - 1)) begin
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_DONE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        ST_WAIT_IDLE: begin
          if (exec_if.cnn_inst_ready) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign exec_if.cnn_inst    = inst_q;
  assign exec_if.cnn_inst_en = en_q;
  assign busy_o              = busy_q;
  assign done_o              = done_q;
  assign err_tmo_o           = err_q;

endmodule
